// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: in1 - in2 - borrow_in, LSB first, one full-subtractor cell.
// Define SUB_OVERFLOW_EN to add a registered signed-overflow output.
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         borrow_in,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow_out
`ifdef SUB_OVERFLOW_EN
  ,
  output logic         overflow
`endif
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  res_q, res_d;
  logic          br_q, br_d;
  logic [CW-1:0] count_q, count_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N-1:0]  diff_q, diff_d;
  logic          borrow_out_q, borrow_out_d;

`ifdef SUB_OVERFLOW_EN
  logic msb1_q, msb1_d;
  logic msb2_q, msb2_d;
  logic overflow_q, overflow_d;
`endif

  logic         d_bit;
  logic         br_next;
  logic [N-1:0] a_shift;
  logic [N-1:0] b_shift;
  logic [N-1:0] res_shift;

  // The single full-subtractor cell, fed by the LSBs of the operand shifters.
  assign d_bit   = a_q[0] ^ b_q[0] ^ br_q;
  assign br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

  // Operands shift right; each new difference bit enters the result from the MSB side.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_shift
      if (gi == N - 1) begin : g_msb
        assign a_shift[gi]   = 1'b0;
        assign b_shift[gi]   = 1'b0;
        assign res_shift[gi] = d_bit;
      end else begin : g_low
        assign a_shift[gi]   = a_q[gi+1];
        assign b_shift[gi]   = b_q[gi+1];
        assign res_shift[gi] = res_q[gi+1];
      end
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    br_d         = br_q;
    count_d      = count_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
`ifdef SUB_OVERFLOW_EN
    msb1_d       = msb1_q;
    msb2_d       = msb2_q;
    overflow_d   = overflow_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        if (start) begin
          a_d     = in1;
          b_d     = in2;
          br_d    = borrow_in;
          res_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef SUB_OVERFLOW_EN
          msb1_d  = in1[N-1];
          msb2_d  = in2[N-1];
`endif
        end
      end

      SHIFT: begin
        a_d     = a_shift;
        b_d     = b_shift;
        res_d   = res_shift;
        br_d    = br_next;
        count_d = count_q + CW'(1);
        if (count_q == LAST) begin
          // Results are published straight from the final bit so they appear with done.
          state_d      = DONE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          diff_d       = res_shift;
          borrow_out_d = br_next;
`ifdef SUB_OVERFLOW_EN
          overflow_d   = (msb1_q != msb2_q) && (d_bit != msb1_q);
`endif
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      br_q         <= 1'b0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      msb1_q       <= 1'b0;
      msb2_q       <= 1'b0;
      overflow_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      br_q         <= br_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
`ifdef SUB_OVERFLOW_EN
      msb1_q       <= msb1_d;
      msb2_q       <= msb2_d;
      overflow_q   <= overflow_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
`ifdef SUB_OVERFLOW_EN
  assign overflow   = overflow_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (N=4): directed vectors, latency, busy-ignore, reset abort.
module tb_serial_subtractor;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow_out;
`ifdef SUB_OVERFLOW_EN
  logic         overflow;
`endif

  serial_subtractor #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in1        (in1),
    .in2        (in2),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SUB_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] d;
    logic         b;
    logic         ov;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           total = 0;
  int           bad = 0;
  int           done_seen = 0;
  int           accepted = 0;
  logic [N-1:0] last_diff = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done: got done=1 required no pending result");
      end else begin
        mon_e = exp_q.pop_front();
        $display("txn diff=%h borrow_out=%b (expect %h/%b)", diff, borrow_out, mon_e.d, mon_e.b);
        check("diff", 32'(diff), 32'(mon_e.d));
        check("borrow_out", 32'(borrow_out), 32'(mon_e.b));
`ifdef SUB_OVERFLOW_EN
        check("overflow", 32'(overflow), 32'(mon_e.ov));
`endif
      end
    end
  end

  task automatic push_exp(input logic [N-1:0] ed, input logic eb, input logic eov);
    exp_t e;
    e.d  = ed;
    e.b  = eb;
    e.ov = eov;
    exp_q.push_back(e);
  endtask

  // Expects N busy cycles then a done cycle; inputs are scrambled after acceptance.
  task automatic wait_result(input logic [N-1:0] ed);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("busy_shift", 32'(busy), 32'd1);
      check("diff_hold", 32'(diff), 32'(last_diff));
    end
    @(negedge clk);
    check("done_latency", 32'(done), 32'd1);
    check("busy_in_done", 32'(busy), 32'd0);
    last_diff = ed;
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bi,
                        input logic [N-1:0] ed, input logic eb, input logic eov);
    push_exp(ed, eb, eov);
    in1       = a;
    in2       = b;
    borrow_in = bi;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    accepted++;
    in1       = ~a;
    in2       = ~b;
    borrow_in = ~bi;
    wait_result(ed);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in1       = '0;
    in2       = '0;
    borrow_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    run_op(4'd9, 4'd3, 1'b0, 4'h6, 1'b0, 1'b1);
    run_op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1);
    run_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);

    // Abort 9-3 during its second SHIFT cycle.
    in1 = 4'd9; in2 = 4'd3; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow_out), 32'd0);
    last_diff = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      @(negedge clk);
      check("no_done_after_abort", 32'(done), 32'd0);
    end
    run_op(4'd12, 4'd5, 1'b0, 4'h7, 1'b0, 1'b1);

    // start held high through SHIFT: only the DONE cycle may accept 5-5.
    push_exp(4'h6, 1'b0, 1'b1);
    push_exp(4'h0, 1'b0, 1'b0);
    in1 = 4'd9; in2 = 4'd3; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    in1 = 4'd5; in2 = 4'd5;
    accepted++;
    wait_result(4'h6);
    @(posedge clk);
    #1;
    start = 1'b0;
    in1 = 4'd0; in2 = 4'd0;
    accepted++;
    wait_result(4'h0);

    run_op(4'd15, 4'd0, 1'b1, 4'hE, 1'b0, 1'b0);
    run_op(4'd0, 4'd15, 1'b0, 4'h1, 1'b1, 1'b0);
    run_op(4'd0, 4'd15, 1'b1, 4'h0, 1'b1, 1'b0);
    run_op(4'd8, 4'd1, 1'b0, 4'h7, 1'b0, 1'b1);
    run_op(4'd7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1);
    run_op(4'd5, 4'd3, 1'b0, 4'h2, 1'b0, 1'b0);

    repeat (N + 2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_per_start", 32'(done_seen), 32'(accepted));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
